// File: rtl/sha2_stream_core.sv
// Multi-block SHA-256 compression engine with valid/ready streaming and 1/2/4 rounds per cycle.
// Optional SHA-224 support is compiled in when SHA2_STREAM_SHA224_EN is defined.
module sha2_stream_core #(
   parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] block,
   input  logic         in_first,
   input  logic         in_last,
   input  logic         mode224,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] digest,
   output logic         busy
);

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned NUM_ROUNDS = 64;
   localparam int unsigned CNT_W      = 7;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ROUND  = 2'd1;
   localparam logic [1:0] S_UPDATE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rounds
      $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [WORD_W-1:0] K [NUM_ROUNDS] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [WORD_W-1:0] IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   logic [1:0]        state_q, state_d;
   logic              in_ready_d, out_valid_d, busy_d;
   logic [WORD_W-1:0] h_q [8];
   logic [WORD_W-1:0] v_q [8];
   logic [WORD_W-1:0] w_q [16];
   logic [CNT_W-1:0]  t_q;
   logic              last_q;
   logic [WORD_W-1:0] iv_sel [8];
   logic [WORD_W-1:0] rv [8];
   logic [WORD_W-1:0] rw [16];
   logic [WORD_W-1:0] t1, t2, wn;
   logic [WORD_W-1:0] hsum [8];
   logic [255:0]      digest_new;

`ifdef SHA2_STREAM_SHA224_EN
   localparam logic [WORD_W-1:0] IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };
   logic mode_q;

   always_comb begin
      iv_sel = mode224 ? IV224 : IV256;
   end
`else
   logic unused_mode;
   assign unused_mode = mode224;

   always_comb begin
      iv_sel = IV256;
   end
`endif

   // Next state and registered-output targets
   always_comb begin
      state_d     = state_q;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      case (state_q)
         S_IDLE:   if (in_valid && in_ready) state_d = S_ROUND;
         S_ROUND:  if (t_q == CNT_W'(NUM_ROUNDS - ROUNDS_PER_CYCLE)) state_d = S_UPDATE;
         S_UPDATE: state_d = last_q ? S_DONE : S_IDLE;
         S_DONE:   if (out_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         busy      <= busy_d;
      end
   end

   // R chained rounds; the window always shifts so W[t+16] is ready when needed
   always_comb begin
      rv = v_q;
      rw = w_q;
      t1 = '0;
      t2 = '0;
      wn = '0;
      for (int unsigned r = 0; r < ROUNDS_PER_CYCLE; r++) begin
         t1 = rv[7] + bsig1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6]))
              + K[6'(t_q) + 6'(r)] + rw[0];
         t2 = bsig0(rv[0]) + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
         wn = ssig1(rw[14]) + rw[9] + ssig0(rw[1]) + rw[0];
         rv[7] = rv[6];
         rv[6] = rv[5];
         rv[5] = rv[4];
         rv[4] = rv[3] + t1;
         rv[3] = rv[2];
         rv[2] = rv[1];
         rv[1] = rv[0];
         rv[0] = t1 + t2;
         for (int j = 0; j < 15; j++) rw[j] = rw[j+1];
         rw[15] = wn;
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) hsum[i] = h_q[i] + v_q[i];
      digest_new = {hsum[0], hsum[1], hsum[2], hsum[3], hsum[4], hsum[5], hsum[6], hsum[7]};
`ifdef SHA2_STREAM_SHA224_EN
      if (mode_q) digest_new[31:0] = '0;
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) begin
            h_q[i] <= '0;
            v_q[i] <= '0;
         end
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
         t_q    <= '0;
         last_q <= 1'b0;
         digest <= '0;
`ifdef SHA2_STREAM_SHA224_EN
         mode_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  for (int i = 0; i < 8; i++) begin
                     if (in_first) begin
                        h_q[i] <= iv_sel[i];
                        v_q[i] <= iv_sel[i];
                     end else begin
                        v_q[i] <= h_q[i];
                     end
                  end
                  for (int i = 0; i < 16; i++) w_q[i] <= block[32*(15-i) +: 32];
                  t_q    <= '0;
                  last_q <= in_last;
`ifdef SHA2_STREAM_SHA224_EN
                  if (in_first) mode_q <= mode224;
`endif
               end
            end
            S_ROUND: begin
               v_q <= rv;
               w_q <= rw;
               t_q <= t_q + CNT_W'(ROUNDS_PER_CYCLE);
            end
            S_UPDATE: begin
               h_q <= hsum;
               if (last_q) digest <= digest_new;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sha2_stream_core.md
# sha2_stream_core

Multi-block SHA-2 compression engine with a valid/ready streaming interface. It accepts pre-padded 512-bit message blocks, chains the intermediate hash across blocks of one message, and presents a 256-bit digest on the last block. It supersedes the single-block `sha256` engine, adding a configurable number of rounds per cycle, output back-pressure and optional SHA-224. It sits between the padding/framing logic and the digest consumer.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: compression rounds per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clock` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-low. Sampled on the `clock` rising edge.
- `in_valid` input, 1 bit: `block`, `in_first`, `in_last` and `mode224` are valid.
- `in_ready` output, 1 bit: the core accepts a block this cycle.
- `block` input, 512 bits: padded message block. Word 0 is `block[511:480]` (big-endian words).
- `in_first` input, 1 bit: first block of a message; loads the IV.
- `in_last` input, 1 bit: last block of a message; produces a digest.
- `mode224` input, 1 bit: selects SHA-224 for the message. Sampled with `in_first`.
- `out_valid` output, 1 bit: `digest` holds a final result.
- `out_ready` input, 1 bit: the consumer accepts the digest.
- `digest` output, 256 bits: H0 is in `[255:224]`. In SHA-224 mode `[31:0]` is 0.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- **States:** IDLE, ROUND, UPDATE, DONE.
- **IDLE:** `in_ready`=1. A block is accepted when `in_valid`&&`in_ready`.
  - If `in_first`: H0..H7 load the IV (SHA-256, or SHA-224 when the mode is enabled), then a..h load the same IV.
  - If not `in_first`: a..h load the current H0..H7.
  - W[0..15] load from `block`, round counter t=0. Next state is ROUND.
- **ROUND:** each cycle performs `ROUNDS_PER_CYCLE` sequential rounds t..t+R-1.
  - Ch=(e&f)^(~e&g) and Maj=(a&b)^(a&c)^(b&c). Both are bitwise; logical operators are forbidden.
  - Standard Σ0/Σ1 and T1/T2 apply, with K[t] from a 64-entry constant ROM.
  - Schedule: a 16-word shift window. For t≥16, W[t]=σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16].
  - All additions are mod 2^32 (carries dropped).
  - After t reaches 64 (64/R cycles), the next state is UPDATE.
- **UPDATE (1 cycle):** Hi ← Hi + {a..h}i, mod 2^32. If the accepted block had `in_last`, `digest` is registered from the new H and the next state is DONE. Otherwise the next state is IDLE.
- **DONE:** `out_valid`=1 and `digest` is held stable. On `out_ready`=1 the next state is IDLE. `in_ready`=0 throughout DONE.
- **Boundary conditions:**
  - `in_first` and `in_last` both set: a single-block message.
  - A non-first block arriving after a completed message continues from the final H of that message (no implicit IV reload).
  - `mode224` is ignored on non-first blocks; the mode is latched per message.
  - Inputs while `in_ready`=0 are ignored; no buffering.
  - Reset low in any cycle forces IDLE and clears H, a..h, W and the counter. Any in-flight block is discarded.

## Timing
- **Reset values:** `in_ready`=0 while `reset`=0, and 1 in the first cycle after release. `out_valid`=0, `digest`=0, `busy`=0.
- **Block throughput:** 64/R + 2 cycles per block (accept cycle + ROUND + UPDATE) when the output is not stalled.
- **Latency:** with the last block accepted at edge N, `out_valid` rises after edge N+64/R+1 (R=1: 65 cycles after acceptance).
- **Back-to-back:** `in_ready` returns high in the cycle after UPDATE for non-last blocks, or the cycle after the `out_valid`&&`out_ready` handshake.
- `digest` changes only on the UPDATE→DONE transition.

## Configuration
- `SHA2_STREAM_SHA224_EN`:
  - **Defined:** `mode224` selects the SHA-224 IV (c1059ed8, 367cd507, 3070dd17, f70e5939, ffc00b31, 68581511, 64f98fa7, befa4fa4), and `digest[31:0]` is forced to 0 on output.
  - **Undefined:** `mode224` is ignored (treated as 0), and the IV ROM and masking logic are not compiled.

## Test plan
1. **SHA-256 "abc", single block.** Stimulus: {61626380, 13×00000000, 00000000, 00000018}, first=last=1, R=1. Required: `digest`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, with `out_valid` 65 cycles after acceptance.
2. **Two-block message.** Stimulus: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", padded into 2 blocks (first, then last). Required: 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1. No `out_valid` after block 1.
3. **Rounds per cycle.** Repeat case 1 with R=2 and R=4. Required: identical digest, latency 33 and 17 cycles.
4. **Output back-pressure.** Hold `out_ready`=0 for 10 cycles. Required: `digest` stable, `in_ready`=0 and `out_valid`=1 throughout. Release → IDLE the next cycle.
5. **SHA-224 (macro defined).** Stimulus: "abc" with `mode224`=1. Required: `digest[255:32]`=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7 and `[31:0]`=0. Without the macro, the same stimulus yields the case-1 digest.
6. **Reset mid-operation.** Drop `reset` at round t=30. Required: all outputs at reset values next cycle. A subsequent case-1 block then yields the correct digest.
